// File: rtl/image_pipe_buf.sv
// Elastic buffer for the valid/end/busy image stream: circular store, registered output,
// advisory busy threshold, sticky overflow. Define IMAGE_PIPE_BUF_STATS_EN for the frame counter.
module image_pipe_buf #(
   parameter int DW      = 32,
   parameter int DEPTH   = 16,
   parameter int BUSY_TH = DEPTH - 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DW-1:0]            is_data_in,
   input  logic                     is_valid_in,
   input  logic                     is_end_in,
   output logic                     is_busy_out,
   output logic [DW-1:0]            im_data_out,
   output logic                     im_valid_out,
   output logic                     im_end_out,
   input  logic                     im_busy_in,
   output logic [$clog2(DEPTH):0]   fill_level,
   output logic                     ovf_err,
   output logic [15:0]              frame_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic          last;
      logic [DW-1:0] data;
   } entry_t;

   entry_t          mem [DEPTH];
   entry_t          head;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_next;
   logic            pop;
   logic            push;

   assign head = mem[rd_ptr];

   // A full buffer still accepts a word when the head leaves on the same edge.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      count_next = count;
      pop        = (count != '0) && !im_busy_in;
      push       = is_valid_in && ((count != CW'(DEPTH)) || pop);
      if (push && !pop)
         count_next = count + 1'b1;
      else if (pop && !push)
         count_next = count - 1'b1;
   end

   // NOTE: storage has no reset; contents are don't-care until count covers them.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= '{last: is_end_in, data: is_data_in};
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         is_busy_out <= 1'b0;
         ovf_err     <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (is_valid_in && !push)
            ovf_err <= 1'b1;
         count       <= count_next;
         is_busy_out <= (count_next >= CW'(BUSY_TH));
      end
   end

   // Output register: data holds its last value whenever no word is presented.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         im_data_out  <= '0;
         im_valid_out <= 1'b0;
         im_end_out   <= 1'b0;
      end else if (pop) begin
         im_data_out  <= head.data;
         im_valid_out <= 1'b1;
         im_end_out   <= head.last;
      end else begin
         im_valid_out <= 1'b0;
         im_end_out   <= 1'b0;
      end
   end

   assign fill_level = count;

`ifdef IMAGE_PIPE_BUF_STATS_EN
   logic [15:0] frame_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         frame_q <= '0;
      else if (pop && head.last)
         frame_q <= frame_q + 16'd1;
   end

   assign frame_cnt = frame_q;
`else
   assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_image_pipe_buf.sv
// Randomised bench for image_pipe_buf, checked every cycle against a queue-based model.
module tb_image_pipe_buf;

   localparam int DW      = 32;
   localparam int DEPTH   = 16;
   localparam int BUSY_TH = 12;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [DW-1:0]          is_data_in;
   logic                   is_valid_in;
   logic                   is_end_in;
   logic                   is_busy_out;
   logic [DW-1:0]          im_data_out;
   logic                   im_valid_out;
   logic                   im_end_out;
   logic                   im_busy_in;
   logic [$clog2(DEPTH):0] fill_level;
   logic                   ovf_err;
   logic [15:0]            frame_cnt;

   image_pipe_buf #(.DW(DW), .DEPTH(DEPTH), .BUSY_TH(BUSY_TH)) dut (
      .clk          (clk),
      .rst          (rst),
      .is_data_in   (is_data_in),
      .is_valid_in  (is_valid_in),
      .is_end_in    (is_end_in),
      .is_busy_out  (is_busy_out),
      .im_data_out  (im_data_out),
      .im_valid_out (im_valid_out),
      .im_end_out   (im_end_out),
      .im_busy_in   (im_busy_in),
      .fill_level   (fill_level),
      .ovf_err      (ovf_err),
      .frame_cnt    (frame_cnt)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int out_cnt  = 0;

   // Reference model: a FIFO queue of {end, data} plus the expected output register.
   logic [DW:0]   q[$];
   logic          m_valid, m_end, m_busy, m_ovf;
   logic [DW-1:0] m_data;
   logic [15:0]   m_frames;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_valid  = 1'b0;
      m_end    = 1'b0;
      m_busy   = 1'b0;
      m_ovf    = 1'b0;
      m_data   = '0;
      m_frames = '0;
   endtask

   task automatic model_edge();
      logic [DW:0] e;
      if (q.size() != 0 && !im_busy_in) begin
         e       = q.pop_front();
         m_valid = 1'b1;
         m_data  = e[DW-1:0];
         m_end   = e[DW];
         if (e[DW])
            m_frames = m_frames + 16'd1;
      end else begin
         m_valid = 1'b0;
         m_end   = 1'b0;
      end
      if (is_valid_in) begin
         if (q.size() < DEPTH)
            q.push_back({is_end_in, is_data_in});
         else
            m_ovf = 1'b1;
      end
      m_busy = (q.size() >= BUSY_TH);
   endtask

   task automatic compare_all();
      logic [15:0] exp_frames;
`ifdef IMAGE_PIPE_BUF_STATS_EN
      exp_frames = m_frames;
`else
      exp_frames = 16'd0;
`endif
      check("valid", im_valid_out, m_valid);
      check("end",   im_end_out,   m_end);
      check("data",  im_data_out,  m_data);
      check("fill",  fill_level,   q.size());
      check("busy",  is_busy_out,  m_busy);
      check("ovf",   ovf_err,      m_ovf);
      check("frames", frame_cnt,   exp_frames);
      if (im_valid_out)
         out_cnt++;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic apply_reset();
      is_valid_in = 1'b0;
      is_end_in   = 1'b0;
      is_data_in  = '0;
      im_busy_in  = 1'b0;
      rst         = 1'b1;
      #3;
      model_reset();
      compare_all();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Sender honours is_busy_out with two cycles of latency; downstream busy by mode.
   task automatic stream(input int n, input int mode);
      int sent = 0;
      int cyc  = 0;
      logic busy_prev = 1'b0;
      logic busy_now  = 1'b0;
      while (sent < n && cyc < 2000) begin
         im_busy_in  = (mode == 0) ? ((cyc / 3) % 2 == 1) : ($urandom_range(3) == 0);
         is_valid_in = !busy_prev;
         is_data_in  = $urandom;
         is_end_in   = $urandom_range(1);
         if (is_valid_in)
            sent++;
         step();
         busy_prev = busy_now;
         busy_now  = is_busy_out;
         cyc++;
      end
      check("stream_budget", sent, n);
      is_valid_in = 1'b0;
      im_busy_in  = 1'b0;
      for (int i = 0; i < DEPTH + 4; i++)
         step();
   endtask

   initial begin
      rst = 1'b1;
      apply_reset();

      // Single word into an empty buffer: two-clock latency.
      is_data_in  = 32'hA5A5_A5A5;
      is_end_in   = 1'b1;
      is_valid_in = 1'b1;
      step();
      check("single_fill1", fill_level, 1);
      check("single_nvalid", im_valid_out, 0);
      is_valid_in = 1'b0;
      is_end_in   = 1'b0;
      step();
      check("single_valid", im_valid_out, 1);
      check("single_data", im_data_out, 32'hA5A5_A5A5);
      check("single_end", im_end_out, 1);
      check("single_fill0", fill_level, 0);
      step();

      // Fill against a busy downstream, overflow, then full with simultaneous pop.
      im_busy_in  = 1'b1;
      is_valid_in = 1'b1;
      for (int i = 0; i < 12; i++) begin
         is_data_in = $urandom;
         is_end_in  = (i % 5 == 4);
         step();
      end
      check("fill_busy12", is_busy_out, 1);
      for (int i = 0; i < 4; i++) begin
         is_data_in = $urandom;
         step();
      end
      check("fill_16", fill_level, 16);
      check("fill_no_ovf", ovf_err, 0);
      is_data_in = 32'hDEAD_BEEF;
      step();
      check("ovf_set", ovf_err, 1);
      check("ovf_fill", fill_level, 16);
      im_busy_in = 1'b0;
      is_data_in = 32'h1234_5678;
      step();
      check("full_pop_fill", fill_level, 16);
      check("full_pop_ovf", ovf_err, 1);
      is_valid_in = 1'b0;
      for (int i = 0; i < DEPTH + 3; i++)
         step();
      check("drained", fill_level, 0);

      // Continuous stream with toggling downstream busy.
      apply_reset();
      out_cnt = 0;
      stream(100, 0);
      check("stream_count", out_cnt, 100);
      check("stream_ovf", ovf_err, 0);

      // Pointer wrap with random downstream busy.
      out_cnt = 0;
      stream(40, 1);
      check("wrap_count", out_cnt, 40);

      // Three frames of five words, then a reset in the middle of a frame.
      apply_reset();
      for (int f = 0; f < 3; f++) begin
         for (int w = 0; w < 5; w++) begin
            is_valid_in = 1'b1;
            is_data_in  = $urandom;
            is_end_in   = (w == 4);
            step();
         end
      end
      is_valid_in = 1'b0;
      is_end_in   = 1'b0;
      for (int i = 0; i < 4; i++)
         step();
`ifdef IMAGE_PIPE_BUF_STATS_EN
      check("frames3", frame_cnt, 3);
`else
      check("frames3", frame_cnt, 0);
`endif
      is_valid_in = 1'b1;
      for (int w = 0; w < 3; w++) begin
         is_data_in = $urandom;
         step();
      end
      rst = 1'b1;
      #1;
      check("rst_valid", im_valid_out, 0);
      check("rst_data", im_data_out, 0);
      check("rst_fill", fill_level, 0);
      check("rst_frames", frame_cnt, 0);
      check("rst_busy", is_busy_out, 0);
      apply_reset();
      for (int w = 0; w < 5; w++) begin
         is_valid_in = 1'b1;
         is_data_in  = $urandom;
         is_end_in   = (w == 4);
         step();
      end
      is_valid_in = 1'b0;
      is_end_in   = 1'b0;
      for (int i = 0; i < 4; i++)
         step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
